// File: rtl/da_egress_arbiter_if.sv
// Bundle between the requesters, the egress arbiter and the dest-append packetizer.
// stall_cnt_out exists only when DA_ARB_STALL_CNT_EN is defined.
interface da_egress_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int WIDTH_DATA       = 12,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1
);
  logic [NUM_REQ*WIDTH_DATA-1:0]       req_data_in;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_dst_in;
  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0] req_vc_in;
  logic [NUM_REQ-1:0]                  req_valid_in;
  logic [NUM_REQ-1:0]                  req_ready_out;
  logic [WIDTH_DATA-1:0]               data_out;
  logic [ADDRESS_WIDTH-1:0]            dst_out;
  logic [VC_ADDRESS_WIDTH-1:0]         vc_out;
  logic                                valid_out;
  logic                                ready_in;
  logic [NUM_REQ-1:0]                  grant_out;
  logic                                idle_out;
`ifdef DA_ARB_STALL_CNT_EN
  logic [15:0]                         stall_cnt_out;

  modport master (
    input  req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
    output req_ready_out, data_out, dst_out, vc_out, valid_out, grant_out, idle_out,
    output stall_cnt_out
  );
  modport slave (
    output req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
    input  req_ready_out, data_out, dst_out, vc_out, valid_out, grant_out, idle_out,
    input  stall_cnt_out
  );
`else
  modport master (
    input  req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
    output req_ready_out, data_out, dst_out, vc_out, valid_out, grant_out, idle_out
  );
  modport slave (
    output req_data_in, req_dst_in, req_vc_in, req_valid_in, ready_in,
    input  req_ready_out, data_out, dst_out, vc_out, valid_out, grant_out, idle_out
  );
`endif
endinterface

// File: rtl/da_egress_arbiter.sv
// Round-robin, burst-locking arbiter sharing one dest-append egress port among NUM_REQ requesters.
// Optional macro DA_ARB_STALL_CNT_EN adds a saturating output-stall cycle counter.
module da_egress_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int WIDTH_DATA       = 12,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int MAX_BURST        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  da_egress_arbiter_if.master    bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               ptr_q, ptr_d;
  logic [IW-1:0]               gidx_q, gidx_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [WIDTH_DATA-1:0]       data_q, data_d;
  logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
  logic                        valid_q, valid_d;

  logic                        slot_free;
  logic [IW-1:0]               pick_idx;
  logic [NUM_REQ-1:0]          req_ready;
  logic [BW-1:0]               beat_inc;

  logic [WIDTH_DATA-1:0]       data_arr [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0]    dst_arr  [NUM_REQ];
  logic [VC_ADDRESS_WIDTH-1:0] vc_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data_in[gi*WIDTH_DATA +: WIDTH_DATA];
    assign dst_arr[gi]  = bus.req_dst_in[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign vc_arr[gi]   = bus.req_vc_in[gi*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
  end

  assign slot_free = !valid_q || bus.ready_in;
  assign beat_inc  = beat_q + BW'(1);

  // Walk downward so the candidate closest after the pointer is the last (winning) write.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    pick_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(ptr_q) + k) % NUM_REQ;
      cand = IW'(idx);
      if (bus.req_valid_in[cand]) pick_idx = cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    data_d    = data_q;
    dst_d     = dst_q;
    vc_d      = vc_q;
    valid_d   = slot_free ? 1'b0 : valid_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid_in) begin
          state_d = ST_GRANT;
          gidx_d  = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          beat_d  = '0;
        end
      end
      ST_GRANT: begin
        // A stalled output slot freezes everything, including the release decision.
        if (slot_free) begin
          req_ready[gidx_q] = 1'b1;
          if (bus.req_valid_in[gidx_q]) begin
            data_d  = data_arr[gidx_q];
            dst_d   = dst_arr[gidx_q];
            vc_d    = vc_arr[gidx_q];
            valid_d = 1'b1;
            beat_d  = beat_inc;
            if (beat_inc == BW'(MAX_BURST)) begin
              state_d = ST_IDLE;
              ptr_d   = gidx_q;
              grant_d = '0;
            end
          end else begin
            state_d = ST_IDLE;
            ptr_d   = gidx_q;
            grant_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      dst_q   <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      vc_q    <= vc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.req_ready_out = req_ready;
  assign bus.data_out      = data_q;
  assign bus.dst_out       = dst_q;
  assign bus.vc_out        = vc_q;
  assign bus.valid_out     = valid_q;
  assign bus.grant_out     = grant_q;
  assign bus.idle_out      = (state_q == ST_IDLE);

`ifdef DA_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !bus.ready_in && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt_out = stall_q;
`endif
endmodule

// File: tb/tb_da_egress_arbiter.sv
// Randomized and directed bench for da_egress_arbiter against a queue-based reference model.
// Build with DA_ARB_STALL_CNT_EN defined to also check the stall counter.
module tb_da_egress_arbiter;
  localparam int NR = 4;
  localparam int W  = 12;
  localparam int AW = 4;
  localparam int VW = 1;
  localparam int MB = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [VW-1:0] v;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  da_egress_arbiter_if #(.NUM_REQ(NR), .WIDTH_DATA(W), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW)) bus ();

  da_egress_arbiter #(
    .NUM_REQ(NR), .WIDTH_DATA(W), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  beat_t src_q [NR][$];
  beat_t out_q [$];
  bit    presenting [NR];
  int    glog [$];
  logic [NR-1:0] prev_grant = '0;
  int    ready_force = -1;

  // Reference model state: who owns the port, where round-robin resumes, the output register.
  int          m_owner;
  int          m_ptr;
  int          m_beats;
  logic        m_valid;
  beat_t       m_out;
  int unsigned m_stall;
  int          beat_no = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_beat(int r, logic [W-1:0] d, logic [AW-1:0] a, logic [VW-1:0] v);
    beat_t b;
    b.d = d; b.a = a; b.v = v;
    src_q[r].push_back(b);
  endtask

  task automatic model_clear();
    m_owner = -1; m_ptr = NR - 1; m_beats = 0; m_valid = 1'b0; m_out = '0; m_stall = 0;
    out_q.delete();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      presenting[i] = 1'b0;
    end
    bus.req_valid_in = '0; bus.req_data_in = '0; bus.req_dst_in = '0; bus.req_vc_in = '0;
    bus.ready_in = 1'b0;
  endtask

  task automatic do_reset(int dly);
    @(negedge clk);
    #(dly);
    rst_n = 1'b0;
    #1;
    check_val("rst_valid_out", bus.valid_out, 0);
    check_val("rst_grant_out", bus.grant_out, 0);
    check_val("rst_idle_out", bus.idle_out, 1);
    check_val("rst_data_out", {bus.data_out, bus.dst_out, bus.vc_out}, 0);
    check_val("rst_req_ready", bus.req_ready_out, 0);
`ifdef DA_ARB_STALL_CNT_EN
    check_val("rst_stall_cnt", bus.stall_cnt_out, 0);
`endif
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_grant = '0;
  endtask

  task automatic cycle(int p_valid, int p_ready);
    bit    free;
    bit    found;
    logic [NR-1:0] exp_ready;
    beat_t b;
    @(negedge clk);
    check_val("valid_out", bus.valid_out, m_valid);
    if (m_valid) begin
      check_val("data_out", bus.data_out, m_out.d);
      check_val("dst_out", bus.dst_out, m_out.a);
      check_val("vc_out", bus.vc_out, m_out.v);
    end
    check_val("grant_out", bus.grant_out, (m_owner < 0) ? 0 : (1 << m_owner));
    check_val("idle_out", bus.idle_out, (m_owner < 0) ? 1 : 0);
`ifdef DA_ARB_STALL_CNT_EN
    check_val("stall_cnt", bus.stall_cnt_out, m_stall);
`endif
    if (bus.grant_out != '0 && bus.grant_out != prev_grant)
      for (int i = 0; i < NR; i++) if (bus.grant_out[i]) glog.push_back(i);
    prev_grant = bus.grant_out;

    // Requesters hold valid and payload until accepted.
    for (int i = 0; i < NR; i++) begin
      if (!presenting[i] && src_q[i].size() > 0 && $urandom_range(99) < p_valid) presenting[i] = 1'b1;
      bus.req_valid_in[i] = presenting[i];
      b = presenting[i] ? src_q[i][0] : beat_t'($urandom);
      bus.req_data_in[i*W +: W]   = b.d;
      bus.req_dst_in[i*AW +: AW]  = b.a;
      bus.req_vc_in[i*VW +: VW]   = b.v;
    end
    bus.ready_in = (ready_force >= 0) ? ready_force[0] : ($urandom_range(99) < p_ready);
    #1;

    free = !m_valid || bus.ready_in;
    exp_ready = '0;
    if (m_owner >= 0 && free) exp_ready[m_owner] = 1'b1;
    check_val("req_ready_out", bus.req_ready_out, exp_ready);

    if (bus.valid_out && bus.ready_in) begin
      check_val("beat_expected", (out_q.size() != 0), 1);
      if (out_q.size() != 0) begin
        b = out_q.pop_front();
        check_val("beat_payload", {bus.data_out, bus.dst_out, bus.vc_out}, b);
        $display("beat %0d: data=0x%03h dst=0x%0h vc=%0d", beat_no, bus.data_out, bus.dst_out, bus.vc_out);
        beat_no++;
      end
    end

    if (m_valid && !bus.ready_in && m_stall < 32'hFFFF) m_stall++;
    if (m_owner < 0) begin
      if (free) m_valid = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (!found && presenting[c]) begin
          found = 1'b1; m_owner = c; m_beats = 0;
        end
      end
    end else if (free) begin
      if (presenting[m_owner]) begin
        b = src_q[m_owner].pop_front();
        presenting[m_owner] = 1'b0;
        out_q.push_back(b);
        m_out = b; m_valid = 1'b1; m_beats++;
        if (m_beats == MB) begin m_ptr = m_owner; m_owner = -1; end
      end else begin
        m_valid = 1'b0;
        m_ptr = m_owner; m_owner = -1;
      end
    end
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (m_owner < 0) && !m_valid;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic drain(string tag, int max_cycles);
    int n;
    n = 0;
    while (!all_quiet() && n < max_cycles) begin
      cycle(100, 100);
      n++;
    end
    check_val({tag, "_drained"}, all_quiet(), 1);
  endtask

  int st_b, st_a;

  initial begin
    bus.req_valid_in = '0; bus.req_data_in = '0; bus.req_dst_in = '0; bus.req_vc_in = '0;
    bus.ready_in = 1'b0;
    do_reset(0);

    // Single requester, two beats.
    glog.delete();
    push_beat(1, 12'h0A5, 4'h3, 1'b0);
    push_beat(1, 12'h15A, 4'h3, 1'b0);
    drain("single", 20);
    check_val("single_grants", glog.size(), 1);
    if (glog.size() > 0) check_val("single_grant_idx", glog[0], 1);

    // Passthrough of all-ones payload fields.
    push_beat(2, 12'hFFF, 4'hB, 1'b1);
    drain("pass", 20);

    // Full contention from a clean pointer.
    do_reset(3);
    glog.delete();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 5; j++) push_beat(i, 12'($urandom), 4'($urandom), 1'($urandom));
    drain("contend", 200);
    check_val("rr_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) check_val("rr_order", glog[k], k % NR);

    // Backpressure mid-burst for three cycles.
    for (int j = 0; j < 6; j++) push_beat(1, 12'(j * 37 + 5), 4'(j), 1'(j));
    ready_force = 1;
    repeat (3) cycle(100, 100);
`ifdef DA_ARB_STALL_CNT_EN
    st_b = int'(bus.stall_cnt_out);
`endif
    ready_force = 0;
    repeat (3) cycle(100, 100);
    ready_force = 1;
    cycle(100, 100);
`ifdef DA_ARB_STALL_CNT_EN
    st_a = int'(bus.stall_cnt_out);
    check_val("stall_delta", st_a - st_b, 3);
`endif
    ready_force = -1;
    drain("bp", 50);

    // Wrap: after serving req3, req0 wins over req2.
    push_beat(3, 12'h333, 4'h3, 1'b1);
    drain("wrap_a", 20);
    glog.delete();
    push_beat(0, 12'h100, 4'h1, 1'b0);
    push_beat(2, 12'h200, 4'h2, 1'b1);
    drain("wrap_b", 20);
    check_val("wrap_first", (glog.size() > 0) ? glog[0] : -1, 0);
    check_val("wrap_second", (glog.size() > 1) ? glog[1] : -1, 2);

    // Reset in the middle of a burst, then req0 has top priority.
    for (int j = 0; j < 4; j++) push_beat(3, 12'(j + 1), 4'hE, 1'b1);
    repeat (4) cycle(100, 100);
    do_reset(2);
    glog.delete();
    push_beat(0, 12'h0F0, 4'h5, 1'b0);
    push_beat(2, 12'h00F, 4'h6, 1'b1);
    drain("post_rst", 20);
    check_val("rst_first", (glog.size() > 0) ? glog[0] : -1, 0);
    check_val("rst_second", (glog.size() > 1) ? glog[1] : -1, 2);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(NR - 1));
      if ($urandom_range(99) < 50 && src_q[r].size() < 5)
        push_beat(r, 12'($urandom), 4'($urandom), 1'($urandom));
      cycle(70, 60);
    end
    drain("random", 500);
    check_val("out_q_empty", out_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
